// File: rtl/llc_output_if_pkg.sv
// Shared cache payload types and field widths for the LLC output side.
package llc_output_if_pkg;

   localparam int ADDR_BITS    = 32;
   localparam int LINE_BITS    = 128;
   localparam int REQ_ID_BITS  = 4;
   localparam int DEST_ID_BITS = 2;
   localparam int MSG_BITS     = 2;
   localparam int HSIZE_BITS   = 3;
   localparam int HPROT_BITS   = 2;

   typedef struct packed {
      logic [MSG_BITS-1:0]     coh_msg;
      logic [ADDR_BITS-1:0]    addr;
      logic [LINE_BITS-1:0]    line;
      logic [REQ_ID_BITS-1:0]  req_id;
      logic [DEST_ID_BITS-1:0] dest_id;
   } llc_rsp_out_t;

   typedef struct packed {
      logic [MSG_BITS-1:0]     coh_msg;
      logic [ADDR_BITS-1:0]    addr;
      logic [REQ_ID_BITS-1:0]  req_id;
      logic [DEST_ID_BITS-1:0] dest_id;
   } llc_fwd_out_t;

   typedef struct packed {
      logic                  hwrite;
      logic [HSIZE_BITS-1:0] hsize;
      logic [HPROT_BITS-1:0] hprot;
      logic [ADDR_BITS-1:0]  addr;
      logic [LINE_BITS-1:0]  line;
   } llc_mem_req_t;

endpackage

// File: rtl/llc_output_if_if.sv
// Core-side and external-side handshakes of the four LLC output channels.
interface llc_output_if_if;
   import llc_output_if_pkg::*;

   logic         llc_rsp_out_valid_int, llc_rsp_out_ready_int;
   llc_rsp_out_t llc_rsp_out_o;
   logic         llc_rsp_out_valid, llc_rsp_out_ready;
   llc_rsp_out_t llc_rsp_out;

   logic         llc_dma_rsp_out_valid_int, llc_dma_rsp_out_ready_int;
   llc_rsp_out_t llc_dma_rsp_out_o;
   logic         llc_dma_rsp_out_valid, llc_dma_rsp_out_ready;
   llc_rsp_out_t llc_dma_rsp_out;

   logic         llc_fwd_out_valid_int, llc_fwd_out_ready_int;
   llc_fwd_out_t llc_fwd_out_o;
   logic         llc_fwd_out_valid, llc_fwd_out_ready;
   llc_fwd_out_t llc_fwd_out;

   logic         llc_mem_req_valid_int, llc_mem_req_ready_int;
   llc_mem_req_t llc_mem_req_o;
   logic         llc_mem_req_valid, llc_mem_req_ready;
   llc_mem_req_t llc_mem_req;

   modport slave (
      input  llc_rsp_out_valid_int, llc_rsp_out_o, llc_rsp_out_ready,
      output llc_rsp_out_ready_int, llc_rsp_out_valid, llc_rsp_out,
      input  llc_dma_rsp_out_valid_int, llc_dma_rsp_out_o, llc_dma_rsp_out_ready,
      output llc_dma_rsp_out_ready_int, llc_dma_rsp_out_valid, llc_dma_rsp_out,
      input  llc_fwd_out_valid_int, llc_fwd_out_o, llc_fwd_out_ready,
      output llc_fwd_out_ready_int, llc_fwd_out_valid, llc_fwd_out,
      input  llc_mem_req_valid_int, llc_mem_req_o, llc_mem_req_ready,
      output llc_mem_req_ready_int, llc_mem_req_valid, llc_mem_req
   );

   modport master (
      output llc_rsp_out_valid_int, llc_rsp_out_o, llc_rsp_out_ready,
      input  llc_rsp_out_ready_int, llc_rsp_out_valid, llc_rsp_out,
      output llc_dma_rsp_out_valid_int, llc_dma_rsp_out_o, llc_dma_rsp_out_ready,
      input  llc_dma_rsp_out_ready_int, llc_dma_rsp_out_valid, llc_dma_rsp_out,
      output llc_fwd_out_valid_int, llc_fwd_out_o, llc_fwd_out_ready,
      input  llc_fwd_out_ready_int, llc_fwd_out_valid, llc_fwd_out,
      output llc_mem_req_valid_int, llc_mem_req_o, llc_mem_req_ready,
      input  llc_mem_req_ready_int, llc_mem_req_valid, llc_mem_req
   );

endinterface

// File: rtl/llc_output_if_out_buf.sv
// llc_out_buf: 2-entry registered FIFO; both handshake sides decode from registers only.
module llc_out_buf #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid_int,
   output logic                  o_ready_int,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic [1:0][DATA_WIDTH-1:0] r_mem;
   logic                       r_wr, r_rd;
   logic [1:0]                 r_cnt;
   logic                       w_push, w_pop;

   assign o_ready_int = (r_cnt != 2'd2);
   assign o_valid     = (r_cnt != 2'd0);
   assign o_data      = r_mem[r_rd];
   assign w_push      = i_valid_int && o_ready_int;
   assign w_pop       = o_valid && i_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem <= '0;
         r_wr  <= 1'b0;
         r_rd  <= 1'b0;
         r_cnt <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= ~r_wr;
         end
         if (w_pop)
            r_rd <= ~r_rd;
         // Simultaneous push+pop leaves occupancy unchanged.
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/llc_output_if.sv
// LLC output stage: one independent 2-entry buffer per outgoing channel.
module llc_output_if
   import llc_output_if_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   llc_output_if_if.slave   bus
);

   localparam int RSP_W = $bits(llc_rsp_out_t);
   localparam int FWD_W = $bits(llc_fwd_out_t);
   localparam int MEM_W = $bits(llc_mem_req_t);

   logic [RSP_W-1:0] w_rsp_in,  w_rsp_out;
   logic [RSP_W-1:0] w_dma_in,  w_dma_out;
   logic [FWD_W-1:0] w_fwd_in,  w_fwd_out;
   logic [MEM_W-1:0] w_mem_in,  w_mem_out;

   // Payloads cross the buffers as flat vectors; structs live only at this boundary.
   assign w_rsp_in = bus.llc_rsp_out_o;
   assign w_dma_in = bus.llc_dma_rsp_out_o;
   assign w_fwd_in = bus.llc_fwd_out_o;
   assign w_mem_in = bus.llc_mem_req_o;

   assign bus.llc_rsp_out     = llc_rsp_out_t'(w_rsp_out);
   assign bus.llc_dma_rsp_out = llc_rsp_out_t'(w_dma_out);
   assign bus.llc_fwd_out     = llc_fwd_out_t'(w_fwd_out);
   assign bus.llc_mem_req     = llc_mem_req_t'(w_mem_out);

   llc_out_buf #(.DATA_WIDTH(RSP_W)) u_rsp_buf (
      .clk         (clk),
      .rst         (rst),
      .i_valid_int (bus.llc_rsp_out_valid_int),
      .o_ready_int (bus.llc_rsp_out_ready_int),
      .i_data      (w_rsp_in),
      .o_valid     (bus.llc_rsp_out_valid),
      .i_ready     (bus.llc_rsp_out_ready),
      .o_data      (w_rsp_out)
   );

   llc_out_buf #(.DATA_WIDTH(RSP_W)) u_dma_buf (
      .clk         (clk),
      .rst         (rst),
      .i_valid_int (bus.llc_dma_rsp_out_valid_int),
      .o_ready_int (bus.llc_dma_rsp_out_ready_int),
      .i_data      (w_dma_in),
      .o_valid     (bus.llc_dma_rsp_out_valid),
      .i_ready     (bus.llc_dma_rsp_out_ready),
      .o_data      (w_dma_out)
   );

   llc_out_buf #(.DATA_WIDTH(FWD_W)) u_fwd_buf (
      .clk         (clk),
      .rst         (rst),
      .i_valid_int (bus.llc_fwd_out_valid_int),
      .o_ready_int (bus.llc_fwd_out_ready_int),
      .i_data      (w_fwd_in),
      .o_valid     (bus.llc_fwd_out_valid),
      .i_ready     (bus.llc_fwd_out_ready),
      .o_data      (w_fwd_out)
   );

   llc_out_buf #(.DATA_WIDTH(MEM_W)) u_mem_buf (
      .clk         (clk),
      .rst         (rst),
      .i_valid_int (bus.llc_mem_req_valid_int),
      .o_ready_int (bus.llc_mem_req_ready_int),
      .i_data      (w_mem_in),
      .o_valid     (bus.llc_mem_req_valid),
      .i_ready     (bus.llc_mem_req_ready),
      .o_data      (w_mem_out)
   );

endmodule

// File: tb/tb_llc_output_if.sv
// Directed bench for llc_output_if: inputs driven and outputs sampled 1ns after each rising edge.
module tb_llc_output_if;
   import llc_output_if_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   llc_output_if_if u_if ();

   llc_output_if u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      u_if.llc_rsp_out_valid_int     = 1'b0; u_if.llc_rsp_out_o     = '0; u_if.llc_rsp_out_ready     = 1'b0;
      u_if.llc_dma_rsp_out_valid_int = 1'b0; u_if.llc_dma_rsp_out_o = '0; u_if.llc_dma_rsp_out_ready = 1'b0;
      u_if.llc_fwd_out_valid_int     = 1'b0; u_if.llc_fwd_out_o     = '0; u_if.llc_fwd_out_ready     = 1'b0;
      u_if.llc_mem_req_valid_int     = 1'b0; u_if.llc_mem_req_o     = '0; u_if.llc_mem_req_ready     = 1'b0;

      // Reset state
      step(); step();
      chk("rst_rsp_valid", u_if.llc_rsp_out_valid, 0);
      chk("rst_dma_valid", u_if.llc_dma_rsp_out_valid, 0);
      chk("rst_fwd_valid", u_if.llc_fwd_out_valid, 0);
      chk("rst_mem_valid", u_if.llc_mem_req_valid, 0);
      chk("rst_rsp_rdy",   u_if.llc_rsp_out_ready_int, 1);
      chk("rst_fwd_rdy",   u_if.llc_fwd_out_ready_int, 1);
      chk("rst_mem_data",  u_if.llc_mem_req, 0);
      chk("rst_rsp_data",  u_if.llc_rsp_out, 0);
      rst = 1'b1;

      // Single transfer on fwd, pushed on the first edge after reset release
      u_if.llc_fwd_out_ready     = 1'b1;
      u_if.llc_fwd_out_valid_int = 1'b1;
      u_if.llc_fwd_out_o.addr    = 32'h1000;
      step();
      u_if.llc_fwd_out_valid_int = 1'b0;
      chk("single_valid", u_if.llc_fwd_out_valid, 1);
      chk("single_addr",  u_if.llc_fwd_out.addr, 32'h1000);
      step();
      chk("single_empty", u_if.llc_fwd_out_valid, 0);
      chk("single_rdy",   u_if.llc_fwd_out_ready_int, 1);

      // Empty buffer ignores consumer ready
      step();
      chk("underflow_valid", u_if.llc_fwd_out_valid, 0);

      // Backpressure on mem_req
      u_if.llc_mem_req_ready     = 1'b0;
      u_if.llc_mem_req_valid_int = 1'b1;
      u_if.llc_mem_req_o.addr    = 32'h40;
      step();
      chk("bp_rdy_after_a", u_if.llc_mem_req_ready_int, 1);
      u_if.llc_mem_req_o.addr = 32'h80;
      step();
      chk("bp_rdy_full", u_if.llc_mem_req_ready_int, 0);
      u_if.llc_mem_req_o.addr = 32'hC0;
      step();
      chk("bp_rdy_still_full", u_if.llc_mem_req_ready_int, 0);
      chk("bp_head_stable", u_if.llc_mem_req.addr, 32'h40);
      step();
      chk("bp_head_hold", u_if.llc_mem_req.addr, 32'h40);
      u_if.llc_mem_req_valid_int = 1'b0;
      u_if.llc_mem_req_ready     = 1'b1;
      chk("bp_pop0_valid", u_if.llc_mem_req_valid, 1);
      chk("bp_pop0_addr",  u_if.llc_mem_req.addr, 32'h40);
      step();
      chk("bp_pop1_valid", u_if.llc_mem_req_valid, 1);
      chk("bp_pop1_addr",  u_if.llc_mem_req.addr, 32'h80);
      step();
      chk("bp_drained", u_if.llc_mem_req_valid, 0);
      u_if.llc_mem_req_ready = 1'b0;

      // Streaming on rsp_out
      u_if.llc_rsp_out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("stream_rdy", u_if.llc_rsp_out_ready_int, 1);
         u_if.llc_rsp_out_valid_int = 1'b1;
         u_if.llc_rsp_out_o.req_id  = 4'(i);
         step();
         chk("stream_valid", u_if.llc_rsp_out_valid, 1);
         chk("stream_id",    u_if.llc_rsp_out.req_id, i);
      end
      u_if.llc_rsp_out_valid_int = 1'b0;
      step();
      chk("stream_done", u_if.llc_rsp_out_valid, 0);

      // Simultaneous push and pop at count 1
      u_if.llc_rsp_out_ready     = 1'b0;
      u_if.llc_rsp_out_valid_int = 1'b1;
      u_if.llc_rsp_out_o.line    = 128'hAA;
      step();
      chk("pp_head_aa", u_if.llc_rsp_out.line, 128'hAA);
      u_if.llc_rsp_out_o.line = 128'hBB;
      u_if.llc_rsp_out_ready  = 1'b1;
      step();
      u_if.llc_rsp_out_valid_int = 1'b0;
      u_if.llc_rsp_out_ready     = 1'b0;
      chk("pp_valid", u_if.llc_rsp_out_valid, 1);
      chk("pp_line",  u_if.llc_rsp_out.line, 128'hBB);
      chk("pp_rdy",   u_if.llc_rsp_out_ready_int, 1);
      u_if.llc_rsp_out_ready = 1'b1;
      step();
      chk("pp_count_was_1", u_if.llc_rsp_out_valid, 0);
      u_if.llc_rsp_out_ready = 1'b0;

      // Reset mid-operation on dma_rsp_out
      u_if.llc_dma_rsp_out_valid_int = 1'b1;
      u_if.llc_dma_rsp_out_o.req_id  = 4'h3;
      step();
      u_if.llc_dma_rsp_out_o.req_id = 4'h4;
      step();
      u_if.llc_dma_rsp_out_valid_int = 1'b0;
      chk("mr_full_rdy", u_if.llc_dma_rsp_out_ready_int, 0);
      chk("mr_full_val", u_if.llc_dma_rsp_out_valid, 1);
      #1 rst = 1'b0;
      #1;
      chk("mr_async_valid", u_if.llc_dma_rsp_out_valid, 0);
      chk("mr_async_rdy",   u_if.llc_dma_rsp_out_ready_int, 1);
      chk("mr_async_data",  u_if.llc_dma_rsp_out, 0);
      step();
      rst = 1'b1;
      u_if.llc_dma_rsp_out_ready = 1'b1;
      step();
      chk("mr_no_stale", u_if.llc_dma_rsp_out_valid, 0);
      u_if.llc_dma_rsp_out_valid_int = 1'b1;
      u_if.llc_dma_rsp_out_o.req_id  = 4'h9;
      step();
      u_if.llc_dma_rsp_out_valid_int = 1'b0;
      chk("mr_post_valid", u_if.llc_dma_rsp_out_valid, 1);
      chk("mr_post_id",    u_if.llc_dma_rsp_out.req_id, 4'h9);
      step();
      chk("mr_post_drain", u_if.llc_dma_rsp_out_valid, 0);

      // Channel independence: fwd stalled full, others stream
      u_if.llc_fwd_out_ready     = 1'b0;
      u_if.llc_fwd_out_valid_int = 1'b1;
      u_if.llc_fwd_out_o.addr    = 32'h200;
      step();
      u_if.llc_fwd_out_o.addr = 32'h300;
      step();
      u_if.llc_fwd_out_valid_int = 1'b0;
      chk("ind_fwd_full", u_if.llc_fwd_out_ready_int, 0);
      u_if.llc_rsp_out_ready     = 1'b1;
      u_if.llc_dma_rsp_out_ready = 1'b1;
      u_if.llc_mem_req_ready     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         u_if.llc_rsp_out_valid_int     = 1'b1; u_if.llc_rsp_out_o.req_id     = 4'(i);
         u_if.llc_dma_rsp_out_valid_int = 1'b1; u_if.llc_dma_rsp_out_o.req_id = 4'(i + 8);
         u_if.llc_mem_req_valid_int     = 1'b1; u_if.llc_mem_req_o.addr       = 32'(i * 16 + 5);
         step();
         chk("ind_rsp_id",   u_if.llc_rsp_out.req_id, i);
         chk("ind_dma_id",   u_if.llc_dma_rsp_out.req_id, i + 8);
         chk("ind_mem_addr", u_if.llc_mem_req.addr, i * 16 + 5);
         chk("ind_mem_rdy",  u_if.llc_mem_req_ready_int, 1);
         chk("ind_fwd_head", u_if.llc_fwd_out.addr, 32'h200);
      end
      u_if.llc_rsp_out_valid_int     = 1'b0;
      u_if.llc_dma_rsp_out_valid_int = 1'b0;
      u_if.llc_mem_req_valid_int     = 1'b0;
      u_if.llc_fwd_out_ready         = 1'b1;
      step();
      chk("ind_fwd_pop2", u_if.llc_fwd_out.addr, 32'h300);
      chk("ind_rsp_done", u_if.llc_rsp_out_valid, 0);
      step();
      chk("ind_fwd_done", u_if.llc_fwd_out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
